hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter REDIRECT_STAGE, default 3, stage resolving redirects (2 = EX, 3 = MEM).
REQ-003 SHALL have parameter MC_MAX, default 34, multi-cycle timeout in cycles (legal range 2..255).
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports rs1_d, rs2_d  in  REG_AW each  decode-stage source registers.
REQ-007 SHALL have ports rs1_e, rs2_e, rd_e  in  REG_AW each  execute-stage sources and destination.
REQ-008 SHALL have ports rd_m, rd_w  in  REG_AW each  MEM and WB destinations.
REQ-009 SHALL have ports regwrite_m, regwrite_w  in  1 each  MEM and WB write enables.
REQ-010 SHALL have port load_e  in  1  EX instruction writes back memory data.
REQ-011 SHALL have port redirect  in  1  taken branch or jump resolved at REDIRECT_STAGE.
REQ-012 SHALL have ports mc_start_e, mc_done  in  1 each  multi-cycle op present in EX; result ready.
REQ-013 SHALL have ports fwd_a_e, fwd_b_e  out  2 each  EX operand source selects.
REQ-014 SHALL have ports en_f, en_d, en_e  out  1 each  PC, IF/ID and ID/EX register enables.
REQ-015 SHALL have ports flush_d, flush_e, flush_m  out  1 each  clears for IF/ID, ID/EX and EX/MEM.
REQ-016 SHALL have port mc_timeout  out  1  one-cycle pulse on multi-cycle timeout.

Function
REQ-017 Forwarding SHALL be combinational and applied per operand: 10 if regwrite_m, rd_m != 0 and rd_m matches the source; else 01 if regwrite_w, rd_w != 0 and rd_w matches; else 00 (MEM wins).
REQ-018 The FSM SHALL have exactly two states, RUN and MCBUSY, plus an 8-bit cycle counter mc_cnt.
REQ-019 Load-use in RUN (load_e, rd_e != 0, rd_e equals rs1_d or rs2_d) SHALL force en_f=en_d=0 and flush_e=1 for that cycle only.
REQ-020 In RUN with mc_start_e=1 and mc_done=0: en_f=en_d=en_e=0 and flush_m=1 in that cycle; next state MCBUSY; mc_cnt loads 1.
REQ-021 In RUN with mc_start_e=1 and mc_done=1: no stall; state stays RUN.
REQ-022 In MCBUSY, outputs SHALL be en_f=en_d=en_e=0 and flush_m=1; mc_cnt increments each cycle.
REQ-023 In MCBUSY with mc_done=1: enables SHALL be 1 and flush_m=0 that cycle; next state RUN.
REQ-024 In MCBUSY with mc_cnt == MC_MAX and no mc_done: mc_timeout=1 for one cycle, enables=1, next state RUN.
REQ-025 Redirect SHALL override load-use and multi-cycle stalls in any state: en_f=1 and flush_d=flush_e=1; flush_m=1 only when REDIRECT_STAGE==3; next state RUN; mc_cnt cleared.
REQ-026 MC stall SHALL dominate a simultaneous load-use stall; load-use is re-evaluated on return to RUN.
REQ-027 No other combination SHALL assert any flush or deassert any enable.

Reset
REQ-028 While reset=0: state RUN, mc_cnt=0, en_*=1, flush_*=0, mc_timeout=0, perf counters 0; fwd_* follow REQ-017 from inputs.
REQ-029 Reset asserted mid-MCBUSY SHALL abandon the operation with no mc_timeout pulse.

Configuration
REQ-030 With HAZARD_PERF_EN defined, SHALL add outputs perf_stall_cnt and perf_flush_cnt (32 bits each): cycles with en_f=0, and cycles with redirect=1; both saturate at all-ones.
REQ-031 Without HAZARD_PERF_EN, these ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-032 Package hazard_pkg SHALL hold FWD_RF=00, FWD_WB=01, FWD_MEM=10 and the RUN/MCBUSY state encoding.
REQ-033 Sub-module fwd_sel (one operand's REQ-017 comparator) SHALL be instantiated twice.

Verification
REQ-034 rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1, rs1_e=5 -> fwd_a_e=10; with rd_m=0 -> fwd_a_e=01.
REQ-035 load_e=1, rd_e=7, rs2_d=7 -> en_f=en_d=0 and flush_e=1 for exactly one cycle.
REQ-036 mc_start_e for one cycle, mc_done 4 cycles later -> enables low for 4 cycles, high on the done cycle.
REQ-037 MC_MAX=4, mc_start_e with no done -> mc_timeout pulses on the 4th MCBUSY cycle; state RUN.
REQ-038 redirect during MCBUSY, REDIRECT_STAGE=2 -> flush_d=flush_e=1, flush_m=0, en_f=1, RUN next cycle.
REQ-039 reset=0 during MCBUSY -> all enables high and flushes low immediately (asynchronous).

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// FSM state encoding and the multi-cycle counter width.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int MC_CNT_W = 8;

  typedef enum logic {
    RUN    = 1'b0,
    MCBUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding comparator: the youngest in-flight writer wins,
// and register 0 is never forwarded.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rd_m,
  input  logic          regwrite_m,
  input  logic [AW-1:0] rd_w,
  input  logic          regwrite_w,
  output logic [1:0]    sel
);

  always_comb begin
    sel = FWD_RF;
    if (regwrite_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (regwrite_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, multi-cycle
// stall with timeout, redirect flush. Optional HAZARD_PERF_EN adds perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int REDIRECT_STAGE = 3,
  parameter int MC_MAX         = 34
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              load_e,
  input  logic              redirect,
  input  logic              mc_start_e,
  input  logic              mc_done,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              en_f,
  output logic              en_d,
  output logic              en_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              mc_timeout,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  output hz_state_e         dbg_state
);

  localparam logic [MC_CNT_W-1:0] MC_MAX_C            = MC_CNT_W'(MC_MAX);
  localparam logic                FLUSH_M_ON_REDIRECT = (REDIRECT_STAGE == 3);

  hz_state_e             state, next_state;
  logic [MC_CNT_W-1:0]   mc_cnt, mc_cnt_next;
  logic                  load_use;

  fwd_sel #(.AW(REG_AW)) u_fwd_a (
    .rs(rs1_e), .rd_m(rd_m), .regwrite_m(regwrite_m),
    .rd_w(rd_w), .regwrite_w(regwrite_w), .sel(fwd_a_e)
  );

  fwd_sel #(.AW(REG_AW)) u_fwd_b (
    .rs(rs2_e), .rd_m(rd_m), .regwrite_m(regwrite_m),
    .rd_w(rd_w), .regwrite_w(regwrite_w), .sel(fwd_b_e)
  );

  assign load_use  = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      state  <= next_state;
      mc_cnt <= mc_cnt_next;
    end
  end

  // mc_start_e is sampled only in RUN; once MCBUSY is entered the unit holds
  // until mc_done, a timeout at mc_cnt == MC_MAX, or a redirect.
  always_comb begin
    next_state  = state;
    mc_cnt_next = mc_cnt;
    en_f        = 1'b1;
    en_d        = 1'b1;
    en_e        = 1'b1;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    mc_timeout  = 1'b0;
    if (redirect) begin
      flush_d     = 1'b1;
      flush_e     = 1'b1;
      flush_m     = FLUSH_M_ON_REDIRECT;
      next_state  = RUN;
      mc_cnt_next = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (mc_start_e && !mc_done) begin
            en_f        = 1'b0;
            en_d        = 1'b0;
            en_e        = 1'b0;
            flush_m     = 1'b1;
            next_state  = MCBUSY;
            mc_cnt_next = MC_CNT_W'(1);
          end else if (load_use) begin
            en_f    = 1'b0;
            en_d    = 1'b0;
            flush_e = 1'b1;
          end
        end
        MCBUSY: begin
          if (mc_done) begin
            next_state  = RUN;
            mc_cnt_next = '0;
          end else if (mc_cnt == MC_MAX_C) begin
            mc_timeout  = 1'b1;
            next_state  = RUN;
            mc_cnt_next = '0;
          end else begin
            en_f        = 1'b0;
            en_d        = 1'b0;
            en_e        = 1'b0;
            flush_m     = 1'b1;
            mc_cnt_next = mc_cnt + MC_CNT_W'(1);
          end
        end
        default: next_state = RUN;
      endcase
    end
    // Reset is asynchronous, so the control outputs release immediately too.
    if (!reset) begin
      en_f       = 1'b1;
      en_d       = 1'b1;
      en_e       = 1'b1;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
      flush_m    = 1'b0;
      mc_timeout = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!en_f && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
